sigmoid_bwd: RTL and testbench
==============================

Name: sigmoid_bwd

Overview:
- Backward-pass counterpart of the registered sigmoid activation in the FFN datapath.
- Takes the forward sigmoid output y and the upstream gradient g.
- Produces the local gradient delta = g * y * (1 - y) for weight-update logic.
- 3-stage pipeline with valid/ready handshakes on both sides. Sits between the gradient source and the backprop accumulator of the systolic array.

Parameters:
- DATA_W, 16, width of y, g and delta.
- y is unsigned Q0.DATA_W (value = y / 2^DATA_W).
- g and delta are signed with identical fixed-point scaling.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- y_i  input  DATA_W  forward sigmoid output, unsigned Q0.DATA_W
- g_i  input  DATA_W  upstream gradient, signed
- last_i  input  1  marks final element of a vector, passed through
- in_valid_i  input  1  y_i/g_i/last_i valid
- in_ready_o  output  1  block accepts input this cycle
- delta_o  output  DATA_W  local gradient, signed, same scaling as g_i
- last_o  output  1  last_i delayed with its element
- out_valid_o  output  1  delta_o/last_o valid
- out_ready_i  input  1  downstream accepts output

Behaviour:
- Reset: asynchronous on rstn low. All stage valids, data registers, delta_o, last_o and out_valid_o go to 0. Reset mid-stream discards all in-flight elements; no partial output after release.
- Pipeline enable: en = ~v3 | out_ready_i, where v3 is the stage-3 valid. All three stages advance together when en=1. in_ready_o = en, combinational. A transfer occurs when in_valid_i & in_ready_o.
- Stage 1 (S1): on transfer, register y, g, last; v1 <= 1. If en=1 with no input, v1 <= 0 (bubble).
- Stage 2 (S2):
  - om = 2^DATA_W - y1, (DATA_W+1)-bit unsigned; y=0 gives om = 2^DATA_W.
  - p = y1 * om, (2*DATA_W+1) bits.
  - s2 <= p >> DATA_W, truncated. s2 max = 2^(DATA_W-2) (0x4000 at DATA_W=16), unsigned DATA_W bits.
  - g, last and valid move to S2.
- Stage 3 (S3):
  - q = signed(g2) * unsigned(s2), 2*DATA_W+1 bits, signed.
  - delta <= q >>> DATA_W, arithmetic shift, i.e. floor.
  - |delta| <= |g|/4, so no saturation is needed. Result is the low DATA_W bits.
- Outputs: delta_o, last_o and out_valid_o are driven directly from S3 registers.
- Latency: 3 cycles from accepted input to out_valid_o when out_ready_i stays high. Throughput is 1 element/cycle.
- Stall: with out_valid_o=1 and out_ready_i=0, all stages hold. Bubbles in S1/S2 are not compressed. Outputs stay stable until accepted (AXI-style: no change of data while valid & ~ready).
- Simultaneous accept at output and input in the same cycle: both transfers complete; occupancy is unchanged.
- last_o asserts only together with out_valid_o for the element that entered with last_i=1.
- An input with in_valid_i=0 never affects the data registers' visible output (they are don't-care while the stage is invalid, but cleared at reset).

Optional Feature:
- Macro: SIGMOID_BWD_ROUND_EN.
- Defined: both shifts round half-up. s2 = (p + 2^(DATA_W-1)) >> DATA_W and delta = (q + 2^(DATA_W-1)) >>> DATA_W. Ranges unchanged, no overflow.
- Undefined: both shifts truncate as specified in Behaviour (floor).
- Latency and handshake are identical in both builds.

Test Plan:
- Basic: y=0x8000, g=0x0100, out_ready_i=1 -> delta_o=0x0040 exactly 3 cycles after accept; in_ready_o stays 1.
- Negative/floor: y=0x8000, g=0xFF00 -> 0xFFC0. y=0x8000, g=0xFFFF -> 0xFFFF without macro, 0x0000 with SIGMOID_BWD_ROUND_EN.
- Edges: y=0x0000, g=0x7FFF -> 0x0000. y=0xFFFF, g=0x7FFF -> 0x0000 without macro; with macro s2=1 so delta=0x0000 (0x7FFF*1 rounds to 0).
- Backpressure: out_ready_i=0 while streaming 5 elements -> exactly 3 accepted, then in_ready_o=0 and delta_o held stable. Releasing out_ready_i drains all 5 in order with matching last_o; no loss or duplication.
- Random stream: 1000 random y/g with random in_valid_i/out_ready_i -> outputs match reference model g*floor(y*(2^16-y)/2^16)/2^16 (floored), in order.
- Reset mid-stream: rstn low for 1 cycle with 3 elements in flight -> out_valid_o=0, delta_o=0, last_o=0 immediately; no stale output after release. The next input produces a correct result 3 cycles later.

Source files
------------

// File: rtl/sigmoid_bwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sigmoid_bwd                                                      |
// | Purpose : 3-stage sigmoid backward pass, delta = g * y * (1 - y), with     |
// |           valid/ready handshakes. Define SIGMOID_BWD_ROUND_EN to make both |
// |           fixed-point shifts round half-up instead of truncating (floor).  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sigmoid_bwd #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] g_i,
  input  logic              last_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] delta_o,
  output logic              last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam int PW = 2*DATA_W + 1;
  localparam logic [PW-1:0] C_HALF = {{(PW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

  logic              v1_q, v2_q, v3_q;
  logic [DATA_W-1:0] y1_q, g1_q, g2_q, s2_q, delta_q;
  logic              last1_q, last2_q, last3_q;

  logic              en;
  logic [DATA_W:0]   om;
  logic [PW-1:0]     p, p_adj;
  logic signed [PW-1:0] q, q_adj;
  logic [DATA_W-1:0] s2_d, delta_d;
  logic              unused_bits;

  // The whole pipe advances in lock-step; only a stalled stage 3 blocks it.
  assign en         = ~v3_q | out_ready_i;
  assign in_ready_o = en;

  always_comb begin
    om    = {1'b1, {DATA_W{1'b0}}} - {1'b0, y1_q};
    p     = PW'(y1_q) * PW'(om);
    q     = $signed({{(DATA_W+1){g2_q[DATA_W-1]}}, g2_q}) *
            $signed({{(DATA_W+1){1'b0}}, s2_q});
`ifdef SIGMOID_BWD_ROUND_EN
    p_adj = p + C_HALF;
    q_adj = q + $signed(C_HALF);
`else
    p_adj = p;
    q_adj = q;
`endif
    // Taking bits [2W-1:W] is the >>W shift; for q it is the arithmetic floor.
    s2_d    = p_adj[2*DATA_W-1:DATA_W];
    delta_d = q_adj[2*DATA_W-1:DATA_W];
  end

  assign unused_bits = ^{p_adj[PW-1], p_adj[DATA_W-1:0], q_adj[PW-1], q_adj[DATA_W-1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      y1_q    <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      s2_q    <= '0;
      delta_q <= '0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        y1_q    <= y_i;
        g1_q    <= g_i;
        last1_q <= last_i;
      end
      v2_q    <= v1_q;
      g2_q    <= g1_q;
      s2_q    <= s2_d;
      last2_q <= last1_q & v1_q;
      v3_q    <= v2_q;
      delta_q <= delta_d;
      // Gating with the valid keeps a stale last flag out of a bubble.
      last3_q <= last2_q & v2_q;
    end
  end

  assign delta_o     = delta_q;
  assign last_o      = last3_q;
  assign out_valid_o = v3_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_bwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sigmoid_bwd                                                   |
// | Purpose : Self-checking bench for sigmoid_bwd against an arithmetic model. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sigmoid_bwd;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] y_i, g_i, delta_o;
  logic        last_i, in_valid_i, in_ready_o, last_o, out_valid_o, out_ready_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  logic        held = 1'b0;
  logic [15:0] held_d;
  logic        held_l;

  sigmoid_bwd #(.DATA_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .y_i        (y_i),
    .g_i        (g_i),
    .last_i     (last_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .delta_o    (delta_o),
    .last_o     (last_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  // Floor division by 2^16 written with plain integer arithmetic.
  function automatic longint fdiv(input longint a);
    longint d;
    d = a / 65536;
    if ((a % 65536 != 0) && (a < 0)) d = d - 1;
    return d;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] y, input logic [15:0] g);
    longint yy, s, q, d;
    yy = longint'(y);
`ifdef SIGMOID_BWD_ROUND_EN
    s = fdiv(yy * (65536 - yy) + 32768);
    q = longint'($signed(g)) * s;
    d = fdiv(q + 32768);
`else
    s = fdiv(yy * (65536 - yy));
    q = longint'($signed(g)) * s;
    d = fdiv(q);
`endif
    return d[15:0];
  endfunction

  // Compare process: every output handshake is checked against the model queue,
  // and a stalled output must not change until it is taken.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        n_vec++;
        if (!out_valid_o || delta_o !== held_d || last_o !== held_l) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                   out_valid_o, delta_o, last_o, held_d, held_l);
        end
      end
      if (in_valid_i && in_ready_o)
        exp_q.push_back({last_i, model(y_i, g_i)});
      if (out_valid_o && out_ready_i) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got d=%h l=%b, need no output", delta_o, last_o);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({last_o, delta_o} !== e) begin
            n_err++;
            $display("FAIL stream: got d=%h l=%b, need d=%h l=%b", delta_o, last_o, e[15:0], e[16]);
          end
        end
      end
      held   = out_valid_o & ~out_ready_i;
      held_d = delta_o;
      held_l = last_o;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    n_vec++;
    if (got !== need) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] y, input logic [15:0] g,
                       input logic l, input logic ordy, output logic acc);
    @(posedge clk);
    #1;
    in_valid_i  = v;
    y_i         = y;
    g_i         = g;
    last_i      = l;
    out_ready_i = ordy;
    @(negedge clk);
    acc = in_valid_i & in_ready_o;
  endtask

  // One isolated element with the output always ready; pins latency and value.
  task automatic single(input logic [15:0] y, input logic [15:0] g,
                        input logic [15:0] need, input string name);
    int   lat;
    logic rdy;
    @(posedge clk);
    #1;
    in_valid_i  = 1'b1;
    y_i         = y;
    g_i         = g;
    last_i      = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    rdy = in_ready_o;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 8) begin
      rdy = rdy & in_ready_o;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_delta"}, {16'h0, delta_o}, {16'h0, need});
    check({name, "_last"}, {31'h0, last_o}, 32'h1);
    check({name, "_in_ready"}, {31'h0, rdy & in_ready_o}, 32'h1);
  endtask

  task automatic drain();
    logic acc;
    int   k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid_o) && k < 50) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic        acc;
    logic [15:0] by [5];
    logic [15:0] bg [5];
    logic [15:0] ry, rg;
    logic        rl;
    int          i, n, guard;

    rstn = 1'b0;
    y_i = '0; g_i = '0; last_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("reset_delta", {16'h0, delta_o}, 32'h0);
    check("reset_last", {31'h0, last_o}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready_o}, 32'h1);
    @(negedge clk);
    #2 rstn = 1'b1;

    single(16'h8000, 16'h0100, 16'h0040, "basic");
    single(16'h8000, 16'hFF00, 16'hFFC0, "neg");
`ifdef SIGMOID_BWD_ROUND_EN
    single(16'h8000, 16'hFFFF, 16'h0000, "neg_round");
`else
    single(16'h8000, 16'hFFFF, 16'hFFFF, "neg_floor");
`endif
    single(16'h0000, 16'h7FFF, 16'h0000, "y_zero");
    single(16'hFFFF, 16'h7FFF, 16'h0000, "y_max");
    drain();

    // Backpressure: five elements offered against a blocked output.
    for (int k = 0; k < 5; k++) begin
      by[k] = 16'($urandom);
      bg[k] = 16'($urandom);
    end
    i = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, by[i], bg[i], i == 4, 1'b0, acc);
      if (acc) i++;
    end
    check("bp_accepted", 32'(i), 32'd3);
    check("bp_in_ready", {31'h0, in_ready_o}, 32'h0);
    guard = 0;
    while (i < 5 && guard < 50) begin
      drive(1'b1, by[i], bg[i], i == 4, 1'b1, acc);
      if (acc) i++;
      guard++;
    end
    check("bp_all_accepted", 32'(i), 32'd5);
    drain();

    // Random stream with random valid/ready on both sides.
    n = 0;
    guard = 0;
    ry = 16'($urandom); rg = 16'($urandom); rl = 1'($urandom);
    while (n < 1000 && guard < 20000) begin
      drive($urandom_range(0, 9) < 7, ry, rg, rl, $urandom_range(0, 9) < 7, acc);
      if (acc) begin
        n++;
        ry = 16'($urandom); rg = 16'($urandom); rl = 1'($urandom);
      end
      guard++;
    end
    check("random_count", 32'(n), 32'd1000);
    drain();

    // Reset with three elements parked in the pipe.
    for (int k = 0; k < 3; k++) drive(1'b1, 16'h4000 + 16'(k), 16'h1234, 1'b1, 1'b0, acc);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midreset_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("midreset_delta", {16'h0, delta_o}, 32'h0);
    check("midreset_last", {31'h0, last_o}, 32'h0);
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int k = 0; k < 5; k++) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    check("post_reset_idle", {31'h0, out_valid_o}, 32'h0);
    single(16'h8000, 16'h0100, 16'h0040, "post_reset");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
